baud_tick_gen: RTL

Parametrised, runtime-programmable baud/oversample tick generator for the serial controller. It divides Clock by a programmable divisor to produce a one-cycle OversampleTick. It divides that by OVERSAMPLE to produce BaudTick and a MidBitTick at the bit centre. It adds enable, glitch-free divisor reload and a Resync input that lets the receiver re-align bit phase on a start-bit edge.

---
 rtl/baud_tick_gen_if.sv | 26 ++
 rtl/baud_tick_gen.sv | 112 +++++++++++
 2 files changed

// File: rtl/baud_tick_gen_if.sv
// Control/status bundle for the baud/oversample tick generator.
// The controller (master) drives enable, divisor programming and resync.
// The tick generator (slave) returns the ticks, the active divisor and the error strobe.
interface baud_tick_gen_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 Enable;
    logic                 DivLoad;
    logic [CNT_WIDTH-1:0] DivValue;
    logic                 Resync;
    logic                 OversampleTick;
    logic                 BaudTick;
    logic                 MidBitTick;
    logic [CNT_WIDTH-1:0] DivActive;
    logic                 DivError;

    modport master (
        output Enable, DivLoad, DivValue, Resync,
        input  OversampleTick, BaudTick, MidBitTick, DivActive, DivError
    );

    modport slave (
        input  Enable, DivLoad, DivValue, Resync,
        output OversampleTick, BaudTick, MidBitTick, DivActive, DivError
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud/oversample tick generator.
// Clock is divided by DivReg to give OversampleTick. OVERSAMPLE oversample ticks make one bit:
// MidBitTick marks the bit centre and BaudTick marks the bit end.
// A new divisor is only taken at an oversample boundary (wrap or Resync), so no runt periods occur.
module baud_tick_gen #(
    parameter int CNT_WIDTH   = 16,
    parameter int OVERSAMPLE  = 8,
    parameter int DEFAULT_DIV = 28,
    parameter int OS_WIDTH    = 4
) (
    input  logic           Clock,
    input  logic           Reset_n,
    baud_tick_gen_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] DIV_MIN   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [OS_WIDTH-1:0]  BIT_LAST  = OS_WIDTH'(OVERSAMPLE - 1);
    localparam logic [OS_WIDTH-1:0]  BIT_MID   = OS_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_WIDTH-1:0]  BIT_ONE   = OS_WIDTH'(1);

    logic [CNT_WIDTH-1:0] osCntReg;
    logic [OS_WIDTH-1:0]  bitCntReg;
    logic [CNT_WIDTH-1:0] divReg;
    logic [CNT_WIDTH-1:0] pendValReg;
    logic                 pendingReg;
    logic                 osTickReg;
    logic                 baudTickReg;
    logic                 midTickReg;
    logic                 divErrorReg;

    logic wrap;
    logic applyEdge;
    logic loadLegal;
    logic loadIllegal;

    // Decode the wrap event and the boundaries at which a divisor may change.
    always_comb begin
        wrap        = bus.Enable && !bus.Resync && (osCntReg == (divReg - CNT_ONE));
        applyEdge   = wrap || bus.Resync;
        loadLegal   = bus.DivLoad && (bus.DivValue >= DIV_MIN);
        loadIllegal = bus.DivLoad && (bus.DivValue < DIV_MIN);
    end

    // Oversample and bit-phase counters plus the registered tick outputs.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            osCntReg    <= '0;
            bitCntReg   <= '0;
            osTickReg   <= 1'b0;
            baudTickReg <= 1'b0;
            midTickReg  <= 1'b0;
        end else if (bus.Resync) begin
            // Resync restarts bit phase regardless of Enable.
            osCntReg    <= '0;
            bitCntReg   <= '0;
            osTickReg   <= 1'b0;
            baudTickReg <= 1'b0;
            midTickReg  <= 1'b0;
        end else if (bus.Enable) begin
            if (wrap) begin
                osCntReg    <= '0;
                osTickReg   <= 1'b1;
                bitCntReg   <= (bitCntReg == BIT_LAST) ? '0 : (bitCntReg + BIT_ONE);
                baudTickReg <= (bitCntReg == BIT_LAST);
                midTickReg  <= (bitCntReg == BIT_MID);
            end else begin
                osCntReg    <= osCntReg + CNT_ONE;
                osTickReg   <= 1'b0;
                baudTickReg <= 1'b0;
                midTickReg  <= 1'b0;
            end
        end else begin
            // Disabled: counters hold so timing resumes where it stopped.
            osTickReg   <= 1'b0;
            baudTickReg <= 1'b0;
            midTickReg  <= 1'b0;
        end
    end

    // Divisor programming: stage legal requests, commit them only at an oversample boundary.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            divReg      <= DIV_RESET;
            pendValReg  <= '0;
            pendingReg  <= 1'b0;
            divErrorReg <= 1'b0;
        end else begin
            divErrorReg <= loadIllegal;
            if (loadLegal) begin
                if (applyEdge) begin
                    // Request coincides with a boundary: take it straight away.
                    divReg     <= bus.DivValue;
                    pendingReg <= 1'b0;
                end else begin
                    // Latest request overwrites any earlier pending one.
                    pendValReg <= bus.DivValue;
                    pendingReg <= 1'b1;
                end
            end else if (applyEdge && pendingReg) begin
                divReg     <= pendValReg;
                pendingReg <= 1'b0;
            end
        end
    end

    assign bus.OversampleTick = osTickReg;
    assign bus.BaudTick       = baudTickReg;
    assign bus.MidBitTick     = midTickReg;
    assign bus.DivActive      = divReg;
    assign bus.DivError       = divErrorReg;
endmodule
